writeback_block: RTL and testbench

// Final pipeline stage. Consumes the registered outputs of memory_block and selects ALU or load data.

---
 rtl/writeback_block.sv | 128 ++++++++++++
 tb/tb_writeback_block.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_block.sv
// Final pipeline stage: selects ALU or load data, drives the register-file write port and the
// forwarding bus, commits writeback-resolved branches as a registered PC redirect, then squashes
// wrong-path instructions for FLUSH_CYCLES cycles.
// Control encodings (1 bit each): reg_data_ctrl_sig_i 1 = MEM_DATA, 0 = ALU data;
// reg_file_write_en_i 1 = WRITE; branch_from_wb_i 1 = BRANCH.
`timescale 1ns/1ps
module writeback_block #(
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned WORD_WIDTH   = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  is_valid_i,
    input  logic                  reg_data_ctrl_sig_i,
    input  logic                  reg_file_write_en_i,
    input  logic                  branch_from_wb_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
    input  logic [WORD_WIDTH-1:0] mem_data_i,
    input  logic [WORD_WIDTH-1:0] alu_data_i,
    output logic                  rf_write_en_o,
    output logic [ADDR_WIDTH-1:0] rf_write_addr_o,
    output logic [WORD_WIDTH-1:0] rf_write_data_o,
    output logic                  fwd_valid_o,
    output logic [ADDR_WIDTH-1:0] fwd_addr_o,
    output logic [WORD_WIDTH-1:0] fwd_data_o,
    output logic                  branch_valid_o,
    output logic [WORD_WIDTH-1:0] branch_target_o,
    output logic                  flush_o,
    output logic [CNT_WIDTH-1:0]  retired_count_o
);

    localparam logic MEM_DATA = 1'b1;
    localparam logic WRITE    = 1'b1;
    localparam logic BRANCH   = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(15);
    localparam logic [2:0]            FLUSH_INIT = 3'(FLUSH_CYCLES);

    typedef enum logic {StRun, StFlush} state_t;

    state_t                r_state;
    state_t                w_state_d;
    logic [2:0]            r_flush_cnt;
    logic [2:0]            w_flush_cnt_d;
    logic                  r_branch_valid;
    logic [WORD_WIDTH-1:0] r_branch_target;
    logic                  r_flush;
    logic [CNT_WIDTH-1:0]  r_retired;

    logic [WORD_WIDTH-1:0] w_wb_data;
    logic                  w_commit;
    logic                  w_rf_we;
    logic                  w_take_branch;

    // Datapath select and commit qualification; squashed instructions are invisible.
    always_comb begin
        w_wb_data     = (reg_data_ctrl_sig_i == MEM_DATA) ? mem_data_i : alu_data_i;
        w_commit      = is_valid_i && (r_state == StRun);
        // r15 is only ever changed through the redirect path, never the RF port.
        w_rf_we       = w_commit && (reg_file_write_en_i == WRITE)
                        && (reg_dest_addr_i != PC_ADDR);
        w_take_branch = w_commit && (branch_from_wb_i == BRANCH);
    end

    // Flush FSM next-state: a committed branch arms the counter, FLUSH counts down to RUN.
    always_comb begin
        w_state_d     = r_state;
        w_flush_cnt_d = r_flush_cnt;
        unique case (r_state)
            StRun: begin
                if (w_take_branch) begin
                    w_state_d     = StFlush;
                    w_flush_cnt_d = FLUSH_INIT;
                end
            end
            StFlush: begin
                w_flush_cnt_d = r_flush_cnt - 3'd1;
                if (r_flush_cnt == 3'd1) begin
                    w_state_d = StRun;
                end
            end
            default: begin
                w_state_d     = StRun;
                w_flush_cnt_d = 3'd0;
            end
        endcase
    end

    // State, redirect, flush flag and retired counter registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state         <= StRun;
            r_flush_cnt     <= 3'd0;
            r_branch_valid  <= 1'b0;
            r_branch_target <= '0;
            r_flush         <= 1'b0;
            r_retired       <= '0;
        end else begin
            r_state        <= w_state_d;
            r_flush_cnt    <= w_flush_cnt_d;
            r_branch_valid <= w_take_branch;
            if (w_take_branch) begin
                // Clear the Thumb bit; the target holds between redirects.
                r_branch_target <= {w_wb_data[WORD_WIDTH-1:1], 1'b0};
            end
            // flush_o mirrors the registered state so it is high exactly in FLUSH.
            r_flush   <= (w_state_d == StFlush);
            r_retired <= r_retired + CNT_WIDTH'(w_commit);
        end
    end

    // Output wiring; forwarding bus is the RF write port by construction.
    always_comb begin
        rf_write_en_o   = w_rf_we;
        rf_write_addr_o = reg_dest_addr_i;
        rf_write_data_o = w_wb_data;
        fwd_valid_o     = w_rf_we;
        fwd_addr_o      = reg_dest_addr_i;
        fwd_data_o      = w_wb_data;
        branch_valid_o  = r_branch_valid;
        branch_target_o = r_branch_target;
        flush_o         = r_flush;
        retired_count_o = r_retired;
    end

endmodule

// File: tb/tb_writeback_block.sv
// Scoreboard bench for writeback_block: stimulus pushes expected writes/redirects into queues,
// a negedge monitor pops and compares whenever the DUT presents a write or a redirect.
`timescale 1ns/1ps
module tb_writeback_block;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic          ctrl;
    logic          we;
    logic          br;
    logic [3:0]    dest;
    logic [31:0]   mem;
    logic [31:0]   alu;
    logic          rf_write_en_o;
    logic [3:0]    rf_write_addr_o;
    logic [31:0]   rf_write_data_o;
    logic          fwd_valid_o;
    logic [3:0]    fwd_addr_o;
    logic [31:0]   fwd_data_o;
    logic          branch_valid_o;
    logic [31:0]   branch_target_o;
    logic          flush_o;
    logic [CW-1:0] retired_count_o;

    int checks = 0;
    int errors = 0;
    logic [35:0]   wq[$];
    logic [31:0]   bq[$];
    logic [CW-1:0] exp_cnt;

    always #5 clk = ~clk;

    writeback_block #(
        .FLUSH_CYCLES(3),
        .CNT_WIDTH   (CW),
        .ADDR_WIDTH  (4),
        .WORD_WIDTH  (32)
    ) u_dut (
        .clk_i              (clk),
        .reset_n_i          (rst_n),
        .is_valid_i         (valid),
        .reg_data_ctrl_sig_i(ctrl),
        .reg_file_write_en_i(we),
        .branch_from_wb_i   (br),
        .reg_dest_addr_i    (dest),
        .mem_data_i         (mem),
        .alu_data_i         (alu),
        .rf_write_en_o      (rf_write_en_o),
        .rf_write_addr_o    (rf_write_addr_o),
        .rf_write_data_o    (rf_write_data_o),
        .fwd_valid_o        (fwd_valid_o),
        .fwd_addr_o         (fwd_addr_o),
        .fwd_data_o         (fwd_data_o),
        .branch_valid_o     (branch_valid_o),
        .branch_target_o    (branch_target_o),
        .flush_o            (flush_o),
        .retired_count_o    (retired_count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write or redirect the DUT presents must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && rf_write_en_o) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h required no write",
                         rf_write_addr_o, rf_write_data_o);
            end else begin
                logic [35:0] e;
                e = wq.pop_front();
                chk("wr_addr", 32'(rf_write_addr_o), 32'(e[35:32]));
                chk("wr_data", rf_write_data_o, e[31:0]);
                chk("fwd_valid", 32'(fwd_valid_o), 32'd1);
                chk("fwd_addr", 32'(fwd_addr_o), 32'(e[35:32]));
                chk("fwd_data", fwd_data_o, e[31:0]);
            end
        end
        if (rst_n && branch_valid_o) begin
            if (bq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect: got target %h required none", branch_target_o);
            end else begin
                logic [31:0] t;
                t = bq.pop_front();
                chk("redirect_target", branch_target_o, t);
            end
        end
    end

    // Present one instruction for one cycle with its hand-computed expectations.
    task automatic issue(input logic v, input logic ms, input logic w, input logic b,
                         input logic [3:0] d, input logic [31:0] m, input logic [31:0] a,
                         input logic exp_wr, input logic [31:0] exp_data, input logic exp_commit,
                         input logic exp_br, input logic [31:0] exp_tgt);
        valid = v;
        ctrl  = ms;
        we    = w;
        br    = b;
        dest  = d;
        mem   = m;
        alu   = a;
        if (exp_wr) wq.push_back({d, exp_data});
        if (exp_br) bq.push_back(exp_tgt);
        if (exp_commit) exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        chk("rf_write_en", 32'(rf_write_en_o), 32'(exp_wr));
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("retired_count", 32'(retired_count_o), 32'(exp_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        valid   = 1'b0;
        ctrl    = 1'b0;
        we      = 1'b0;
        br      = 1'b0;
        dest    = 4'd0;
        mem     = 32'd0;
        alu     = 32'd0;
        exp_cnt = '0;
        #12;
        chk("reset_flush", 32'(flush_o), 32'd0);
        chk("reset_bvalid", 32'(branch_valid_o), 32'd0);
        chk("reset_target", branch_target_o, 32'd0);
        chk("reset_count", 32'(retired_count_o), 32'd0);
        chk("reset_rf_we", 32'(rf_write_en_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU write, then load write
        issue(1, 0, 1, 0, 4'd3, 32'h0, 32'h1234, 1, 32'h1234, 1, 0, 32'h0);
        issue(1, 1, 1, 0, 4'd7, 32'hDEADBEEF, 32'h20, 1, 32'hDEADBEEF, 1, 0, 32'h0);

        // Redirect via load of 0x101, target 0x100
        issue(1, 1, 0, 1, 4'd15, 32'h0000_0101, 32'h55, 0, 32'h0, 1, 1, 32'h0000_0100);
        chk("redir_flush1", 32'(flush_o), 32'd1);
        chk("redir_bvalid", 32'(branch_valid_o), 32'd1);
        chk("redir_target", branch_target_o, 32'h0000_0100);

        // Three squashed writes during the flush window, then a real write
        for (int i = 0; i < 3; i++) begin
            issue(1, 0, 1, 0, 4'd5, 32'h0, 32'hA0 + 32'(i), 0, 32'h0, 0, 0, 32'h0);
            chk("flush_window", 32'(flush_o), (i < 2) ? 32'd1 : 32'd0);
            chk("bvalid_pulse", 32'(branch_valid_o), 32'd0);
        end
        issue(1, 0, 1, 0, 4'd5, 32'h0, 32'hA3, 1, 32'hA3, 1, 0, 32'h0);
        chk("target_hold", branch_target_o, 32'h0000_0100);

        // Branch that also writes a GPR; then a branch squashed in FLUSH
        issue(1, 0, 1, 1, 4'd9, 32'h0, 32'h0000_2003, 1, 32'h0000_2003, 1, 1, 32'h0000_2002);
        issue(1, 1, 1, 1, 4'd4, 32'h0000_4445, 32'h0, 0, 32'h0, 0, 0, 32'h0);

        // Async reset during flush cycle 2
        chk("pre_reset_flush", 32'(flush_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midflush_reset_flush", 32'(flush_o), 32'd0);
        chk("midflush_reset_count", 32'(retired_count_o), 32'd0);
        chk("midflush_reset_bvalid", 32'(branch_valid_o), 32'd0);
        chk("midflush_reset_target", branch_target_o, 32'd0);
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1, 0, 1, 0, 4'd2, 32'h0, 32'h77, 1, 32'h77, 1, 0, 32'h0);

        // r15 write suppressed but still retires; invalid does nothing
        issue(1, 0, 1, 0, 4'd15, 32'h0, 32'hFFFF, 0, 32'h0, 1, 0, 32'h0);
        issue(0, 0, 1, 0, 4'd6, 32'h0, 32'h66, 0, 32'h0, 0, 0, 32'h0);

        // Counter wrap with a 4-bit counter
        while (exp_cnt != 4'd15) begin
            issue(1, 0, 1, 0, 4'd1, 32'h0, 32'h100 + 32'(exp_cnt), 1, 32'h100 + 32'(exp_cnt),
                  1, 0, 32'h0);
        end
        issue(1, 0, 1, 0, 4'd1, 32'h0, 32'h1FF, 1, 32'h1FF, 1, 0, 32'h0);
        chk("count_wrap", 32'(retired_count_o), 32'd0);

        @(negedge clk);
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        chk("redirect_queue_drained", 32'(bq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
